stim_sequencer: RTL and testbench
=================================

# stim_sequencer

Synthesizable stimulus sequencer for the b01 serial-comparator concolic harness.
- Holds a small program of 3-bit opcodes and holds the DUT in reset for a programmable window.
- Then replays one opcode per clock onto the DUT's `line1`/`line2`/`__obs` inputs.
- Raises a completion handshake at the end and keeps a running step count for trace correlation.
- Sits between the test host (program load and start) and the b01 instance, and replaces free-running testbench stimulus so runs are repeatable on silicon or emulation.

## Interface
Parameters:
- `DEPTH`, 11: opcode memory entries.
- `ADDR_W`, 4: address width; must satisfy 2^ADDR_W ≥ DEPTH.
- `RST_CYC`, 2: cycles `dut_reset` is held high before stepping; legal range 1..15.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; 0 resets the block.
- `load_en`  in  1  write `load_data` to `mem[load_addr]`; ignored while `busy`=1 or `load_addr`≥DEPTH.
- `load_addr`  in  ADDR_W  write address.
- `load_data`  in  3  opcode: bit0 = line1, bit1 = line2, bit2 = obs.
- `start`  in  1  begin a run; sampled only in IDLE.
- `length`  in  ADDR_W+1  number of opcodes to issue; values above DEPTH are clamped to DEPTH.
- `hold`  in  1  freezes stepping in RUN.
- `stop`  in  1  ends a looping run (see Configuration).
- `line1`, `line2`, `obs`  out  1 each  registered DUT stimulus.
- `dut_reset`  out  1  active-high DUT reset.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is exited.
- `done`  out  1  single-cycle completion pulse.
- `pc`  out  ADDR_W  next memory address to issue.
- `step_cnt`  out  32  opcodes issued since the last `start`; saturates at 0xFFFFFFFF.

## Operation
- FSM states and transitions:
  - IDLE → RESET when `start`=1.
  - RESET → RUN after RST_CYC cycles.
  - RUN → DONE when the issued count reaches the clamped length.
  - DONE → IDLE after one cycle.
- IDLE:
  - Outputs are 0.
  - `pc`=0.
  - `step_cnt` holds its last value.
- RESET:
  - `dut_reset`=1 and `busy`=1.
  - A down-counter loads RST_CYC−1 on entry.
  - `step_cnt` clears to 0 on entry.
  - `hold` is ignored.
- RUN:
  - On each edge with `hold`=0: {obs,line2,line1} ← `mem[pc]`, `pc`++ and `step_cnt`++.
  - With `hold`=1, all outputs and `pc` hold.
  - Once the issued count equals the clamped length, the next edge enters DONE regardless of `hold`.
- DONE:
  - Lines clear to 0.
  - `done`=1 for this cycle only, and `busy` stays 1.
- `length`=0: RESET runs normally, then the FSM goes straight to DONE with no opcodes issued.
- `length` is latched when `start` is accepted; later changes to `length` have no effect on that run.
- `start` while `busy`=1 is ignored, and so is `load_en`.
- Memory contents are not cleared by reset. Unwritten entries read as 0 after reset, via a reset-time valid mask.
- Asserting `reset` mid-run returns all outputs to 0 immediately and forces IDLE. The memory is retained.

## Timing
- Reset values: all outputs are 0.
- `start` sampled high at edge E:
  - `busy`=1 and `dut_reset`=1 after E.
  - `dut_reset` falls after E+RST_CYC.
  - The first opcode appears on the lines in the same cycle that `dut_reset` falls.
- A run of N opcodes with no holds:
  - `done` pulses after edge E+RST_CYC+N.
  - `busy` falls one edge later.
- Every held cycle adds one cycle of latency.
- All outputs are registered; nothing is combinational from inputs to outputs.

## Configuration
- Macro: `STIM_SEQ_LOOP_EN`.
- Defined:
  - In RUN, after the last opcode, `pc` wraps to 0 and replay continues.
  - Termination happens only on `stop`=1, sampled in RUN. The opcode already issued on that edge completes, and the next state is DONE.
  - `step_cnt` keeps counting across wraps.
- Undefined:
  - The run is single-pass.
  - `stop` is ignored.

## Test plan
- Reset/idle: `reset`=0 mid-RUN at step 3 → all outputs 0 in the same cycle. After release, IDLE and `busy`=0.
- Basic replay:
  - Setup: load `mem[0..3]` = 001, 010, 100, 111; RST_CYC=2; `length`=4; `start`.
  - Required: `dut_reset` high for 2 cycles, then lines show 001, 010, 100, 111 on consecutive cycles.
  - Required: `done` pulses once, `step_cnt`=4.
- Hold: same program with `hold`=1 for 3 cycles after the second opcode → 010 persists 4 cycles, and `done` is delayed by exactly 3.
- Boundaries:
  - `length`=0 → `done` pulses after E+2 with no line activity.
  - `length`=20 → clamped to 11 opcodes.
  - `start`/`load_en` during `busy` → no effect.
- Loop (with `STIM_SEQ_LOOP_EN`): `length`=3, `stop` asserted at step 7 → opcode sequence 0,1,2,0,1,2,0, then `done`, `step_cnt`=7.
- Loop (without `STIM_SEQ_LOOP_EN`): same stimulus → 3 opcodes issued, `stop` has no effect.

Source files
------------

// File: rtl/stim_sequencer.sv
// stim_sequencer: holds the b01 serial comparator in reset for RST_CYC cycles,
// then replays a loaded program of 3-bit opcodes ({obs,line2,line1}) one per
// clock, pulses done at the end and keeps a saturating step count.
// Optional build macro STIM_SEQ_LOOP_EN: replay wraps until `stop` is seen.
module stim_sequencer #(
  parameter int unsigned DEPTH   = 11,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned RST_CYC = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [2:0]        load_data,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic              hold,
  input  logic              stop,
  output logic              line1,
  output logic              line2,
  output logic              obs,
  output logic              dut_reset,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       step_cnt
);

  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned RCNT_W = 4;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [RCNT_W-1:0] rst_cnt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  pc_q;
  logic [LEN_W-1:0]  pc_nxt_c;
  logic [LEN_W-1:0]  len_clamp_c;
  logic [OP_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [OP_W-1:0]   rd_op_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic              wr_en_c;
  logic [31:0]       step_inc_c;
`ifdef STIM_SEQ_LOOP_EN
  logic              stop_pend;
`else
  logic              unused_stop_c;
  assign unused_stop_c = stop;
`endif

  // pc_q is one bit wider than the address so it can equal a full-depth length
  assign pc        = pc_q[ADDR_W-1:0];
  assign rd_addr_c = pc_q[ADDR_W-1:0];

  // Length clamp, load qualification, saturating step increment, next pc
  always_comb begin
    len_clamp_c = (length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length;
    wr_en_c     = load_en && !busy && ({1'b0, load_addr} < LEN_W'(DEPTH));
    step_inc_c  = (&step_cnt) ? step_cnt : step_cnt + 32'd1;
`ifdef STIM_SEQ_LOOP_EN
    pc_nxt_c    = ((pc_q + LEN_W'(1)) == len_q) ? '0 : pc_q + LEN_W'(1);
`else
    pc_nxt_c    = pc_q + LEN_W'(1);
`endif
  end

  // Opcode read; entries never written since reset read as 0
  always_comb begin
    rd_op_c = '0;
    if ((pc_q < LEN_W'(DEPTH)) && valid[rd_addr_c]) rd_op_c = mem[rd_addr_c];
  end

  // Program storage survives reset
  always_ff @(posedge clock) begin
    if (wr_en_c) mem[load_addr] <= load_data;
  end

  // Written-entry mask, cleared by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) valid <= '0;
    else if (wr_en_c) valid[load_addr] <= 1'b1;
  end

  // Sequencer FSM with registered stimulus, handshake and trace counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      rst_cnt   <= '0;
      len_q     <= '0;
      pc_q      <= '0;
      line1     <= 1'b0;
      line2     <= 1'b0;
      obs       <= 1'b0;
      dut_reset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_cnt  <= '0;
`ifdef STIM_SEQ_LOOP_EN
      stop_pend <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RESET;
            busy      <= 1'b1;
            dut_reset <= 1'b1;
            rst_cnt   <= RCNT_W'(RST_CYC - 1);
            len_q     <= len_clamp_c;
            pc_q      <= '0;
            step_cnt  <= '0;
`ifdef STIM_SEQ_LOOP_EN
            stop_pend <= 1'b0;
`endif
          end
        end
        S_RESET: begin
          if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - RCNT_W'(1);
          end else begin
            // First opcode lands in the same cycle the DUT leaves reset
            dut_reset <= 1'b0;
            if (len_q == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state               <= S_RUN;
              {obs, line2, line1} <= rd_op_c;
              pc_q                <= pc_nxt_c;
              step_cnt            <= step_inc_c;
            end
          end
        end
        S_RUN: begin
`ifdef STIM_SEQ_LOOP_EN
          if (stop_pend) begin
            state               <= S_DONE;
            done                <= 1'b1;
            {obs, line2, line1} <= '0;
          end else begin
            if (stop) stop_pend <= 1'b1;
            if (!hold) begin
              {obs, line2, line1} <= rd_op_c;
              pc_q                <= pc_nxt_c;
              step_cnt            <= step_inc_c;
            end
          end
`else
          if (pc_q == len_q) begin
            state               <= S_DONE;
            done                <= 1'b1;
            {obs, line2, line1} <= '0;
          end else if (!hold) begin
            {obs, line2, line1} <= rd_op_c;
            pc_q                <= pc_nxt_c;
            step_cnt            <= step_inc_c;
          end
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          pc_q  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stim_sequencer.sv
// tb_stim_sequencer: directed bench for stim_sequencer. Expected outputs come
// from an issue-event model: the list of edges at which opcodes are issued is
// derived from length/hold/stop, and every output follows from that list.
module tb_stim_sequencer;

  localparam int DEPTH   = 11;
  localparam int ADDR_W  = 4;
  localparam int RST_CYC = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [2:0]        load_data = '0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   length = '0;
  logic              hold = 1'b0;
  logic              stop = 1'b0;
  logic              line1, line2, obs, dut_reset, busy, done;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       step_cnt;

  int n_checks = 0;
  int n_err    = 0;
  logic [2:0] mem_m [DEPTH];
  logic [2:0] trace_q [$];
  int seen_done;
  int final_cnt;

  stim_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RST_CYC(RST_CYC)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .length(length), .hold(hold),
    .stop(stop), .line1(line1), .line2(line2), .obs(obs),
    .dut_reset(dut_reset), .busy(busy), .done(done), .pc(pc),
    .step_cnt(step_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic load_op(input int a, input logic [2:0] d);
    @(negedge clock);
    load_en = 1'b1; load_addr = ADDR_W'(a); load_data = d;
    @(negedge clock);
    load_en = 1'b0;
    if (a < DEPTH) mem_m[a] = d;
  endtask

  // One run: start at edge k=0, check every cycle through two cycles of IDLE
  task automatic run_case(input string name, input int len,
                          input logic [63:0] hold_mask, input int stop_k,
                          input bit poke);
    int n;
    int done_k;
    int t;
    int iss[$];
    n = (len > DEPTH) ? DEPTH : len;
    if (n == 0) begin
      done_k = RST_CYC;
    end else begin
      t = RST_CYC;
      iss.push_back(t);
`ifdef STIM_SEQ_LOOP_EN
      while (t < stop_k) begin
        t++;
        if (t >= 64 || !hold_mask[t]) iss.push_back(t);
      end
      done_k = stop_k + 1;
`else
      while (iss.size() < n) begin
        t++;
        if (t >= 64 || !hold_mask[t]) iss.push_back(t);
      end
      done_k = t + 1;
`endif
    end
    trace_q.delete();
    seen_done = -1;
    for (int k = 0; k <= done_k + 2; k++) begin
      int issued;
      logic [2:0] e_lines;
      int e_pc;
      @(negedge clock);
      start   = (k == 0);
      length  = (poke && k > 0) ? (ADDR_W+1)'(1) : (ADDR_W+1)'(len);
      hold    = (k < 64) ? hold_mask[k] : 1'b0;
      stop    = (k == stop_k);
      load_en = 1'b0;
      if (poke && (k == 3 || k == done_k + 1)) begin
        start = 1'b1; load_en = 1'b1; load_addr = '0; load_data = 3'b110;
      end
      @(posedge clock);
      #1;
      issued = 0;
      foreach (iss[i]) if (iss[i] <= k) issued++;
      e_lines = (k < done_k && issued > 0) ? mem_m[(issued - 1) % n] : 3'b000;
`ifdef STIM_SEQ_LOOP_EN
      e_pc = (k <= done_k && n > 0) ? issued % n : 0;
`else
      e_pc = (k <= done_k) ? issued : 0;
`endif
      chk({name, ":busy"},      k, 32'(busy),      32'(k <= done_k));
      chk({name, ":dut_reset"}, k, 32'(dut_reset), 32'(k < RST_CYC));
      chk({name, ":done"},      k, 32'(done),      32'(k == done_k));
      chk({name, ":lines"},     k, 32'({obs, line2, line1}), 32'(e_lines));
      chk({name, ":pc"},        k, 32'(pc),        32'(e_pc));
      chk({name, ":step_cnt"},  k, step_cnt,       32'(issued));
      if (done === 1'b1 && seen_done < 0) seen_done = k;
      if (k >= RST_CYC && k < done_k) trace_q.push_back({obs, line2, line1});
    end
    final_cnt = int'(step_cnt);
    @(negedge clock);
    start = 1'b0; hold = 1'b0; stop = 1'b0; load_en = 1'b0; length = '0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 3'b000;
    #12;
    chk("reset:lines",     0, 32'({obs, line2, line1}), 32'd0);
    chk("reset:dut_reset", 0, 32'(dut_reset), 32'd0);
    chk("reset:busy",      0, 32'(busy), 32'd0);
    chk("reset:done",      0, 32'(done), 32'd0);
    chk("reset:pc",        0, 32'(pc), 32'd0);
    chk("reset:step_cnt",  0, step_cnt, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Nothing written yet: entries read as 0
    run_case("unwritten", 2, 64'h0, 0, 1'b0);
    chk("unwritten:final", 0, 32'(final_cnt), 32'd2);

    load_op(0, 3'b001); load_op(1, 3'b010); load_op(2, 3'b100); load_op(3, 3'b111);
    for (int i = 4; i < DEPTH; i++) load_op(i, 3'(i));

    run_case("basic", 4, 64'h0, 0, 1'b0);
    chk("basic:done_at", 0, 32'(seen_done), 32'd6);
    chk("basic:final",   0, 32'(final_cnt), 32'd4);
    chk("basic:ntrace",  0, 32'(trace_q.size()), 32'd4);
    if (trace_q.size() == 4) begin
      chk("basic:op0", 0, 32'(trace_q[0]), 32'h1);
      chk("basic:op1", 1, 32'(trace_q[1]), 32'h2);
      chk("basic:op2", 2, 32'(trace_q[2]), 32'h4);
      chk("basic:op3", 3, 32'(trace_q[3]), 32'h7);
    end

    // start/load_en/length changes while busy must not disturb anything
    run_case("busy_poke", 4, 64'h0, 0, 1'b1);
    chk("busy_poke:final", 0, 32'(final_cnt), 32'd4);
    run_case("after_poke", 4, 64'h0, 0, 1'b0);
    chk("after_poke:mem0", 0, 32'(trace_q[0]), 32'h1);

    run_case("hold", 4, 64'h70, 0, 1'b0);
    chk("hold:done_at", 0, 32'(seen_done), 32'd9);
    chk("hold:ntrace",  0, 32'(trace_q.size()), 32'd7);
    if (trace_q.size() == 7)
      for (int i = 1; i <= 4; i++) chk("hold:op1_held", i, 32'(trace_q[i]), 32'h2);

    run_case("len0", 0, 64'h0, 0, 1'b0);
    chk("len0:done_at", 0, 32'(seen_done), 32'd2);
    chk("len0:final",   0, 32'(final_cnt), 32'd0);

    run_case("len20", 20, 64'h0, 0, 1'b0);
    chk("len20:done_at", 0, 32'(seen_done), 32'd13);
    chk("len20:final",   0, 32'(final_cnt), 32'd11);

    run_case("stop", 3, 64'h0, 8, 1'b0);
`ifdef STIM_SEQ_LOOP_EN
    chk("loop:final",   0, 32'(final_cnt), 32'd7);
    chk("loop:done_at", 0, 32'(seen_done), 32'd9);
    if (trace_q.size() == 7) begin
      chk("loop:op3", 3, 32'(trace_q[3]), 32'h1);
      chk("loop:op6", 6, 32'(trace_q[6]), 32'h1);
    end
`else
    chk("noloop:final",   0, 32'(final_cnt), 32'd3);
    chk("noloop:done_at", 0, 32'(seen_done), 32'd5);
`endif

    // Asynchronous reset in the middle of a run
    @(negedge clock);
    start = 1'b1; length = (ADDR_W+1)'(4);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("midrst:pre_step", 0, step_cnt, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst:lines",     0, 32'({obs, line2, line1}), 32'd0);
    chk("midrst:dut_reset", 0, 32'(dut_reset), 32'd0);
    chk("midrst:busy",      0, 32'(busy), 32'd0);
    chk("midrst:done",      0, 32'(done), 32'd0);
    chk("midrst:pc",        0, 32'(pc), 32'd0);
    chk("midrst:step_cnt",  0, step_cnt, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clock);
      #1;
      chk("post_rst:busy",      k, 32'(busy), 32'd0);
      chk("post_rst:dut_reset", k, 32'(dut_reset), 32'd0);
      chk("post_rst:lines",     k, 32'({obs, line2, line1}), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
